// File: rtl/kernel_loader_pkg.sv
// Shared kernel/DRAM memory parameters, derived lane constants and loader FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kernel_loader_pkg;

  localparam int KL_DRAM_DATA_BITS = 512;
  localparam int KL_DRAM_ADDR_BITS = 29;
  localparam int KL_KER_WIDTH      = 128;
  localparam int KL_KER_NUM        = 1;
  localparam int KL_KER_HEIGHT     = 1920;
  localparam int KL_KER_ADDR_BITS  = $clog2(KL_KER_HEIGHT);
  localparam int KL_LEN_BITS       = 16;

  // Lane index width, kept at least one bit so a single-lane beat still has a legal index.
  function automatic int kl_lane_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Kernel words carried per DRAM beat.
  localparam int KL_R         = KL_DRAM_DATA_BITS / KL_KER_WIDTH;
  localparam int KL_LANE_BITS = kl_lane_bits(KL_R);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RECV  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } ker_loader_state_e;

endpackage

// File: rtl/kernel_loader_beat_splitter.sv
// Holds one DRAM beat and presents it one kernel word (lane 0 first) per shift.
// Latency: load visible on lane the cycle after load; each shift advances one lane.
// Backpressure: none; the owner decides when to load and shift.
module beat_splitter
  import kernel_loader_pkg::*;
#(
  parameter int LANES      = KL_R,
  parameter int LANE_WIDTH = KL_KER_WIDTH,
  parameter int LANE_BITS  = KL_LANE_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic                        shift,
  input  logic [LANES*LANE_WIDTH-1:0] beat,
  output logic [LANE_WIDTH-1:0]       lane,
  output logic [LANE_BITS:0]          lanes_left
);

  logic [LANES*LANE_WIDTH-1:0] shreg;
  logic [LANE_BITS:0]          cnt;

  // Load takes priority; a shift drops the word just consumed and moves the next one to lane 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= beat;
      cnt   <= (LANE_BITS + 1)'(LANES);
    end else if (shift) begin
      shreg <= shreg >> LANE_WIDTH;
      if (cnt != '0) begin
        cnt <= cnt - (LANE_BITS + 1)'(1);
      end
    end
  end

  assign lane       = shreg[LANE_WIDTH-1:0];
  assign lanes_left = cnt;

endmodule

// File: rtl/kernel_loader.sv
// Loads kernel words from one DRAM burst into a kernel bank, one 128-bit word per cycle.
// Latency: req at T+1 after accept; lane k written at B+1+k after beat B; done one cycle after the last write.
// Backpressure: cmd_ready only in IDLE; dram_rd_ready only while waiting for a beat. Option: KER_LOADER_PERF_EN adds perf_cycles.
module kernel_loader
  import kernel_loader_pkg::*;
#(
  parameter int DRAM_DATA_BITS = KL_DRAM_DATA_BITS,
  parameter int DRAM_ADDR_BITS = KL_DRAM_ADDR_BITS,
  parameter int KER_WIDTH      = KL_KER_WIDTH,
  parameter int KER_NUM        = KL_KER_NUM,
  parameter int KER_HEIGHT     = KL_KER_HEIGHT,
  parameter int KER_ADDR_BITS  = $clog2(KER_HEIGHT),
  parameter int LEN_BITS       = KL_LEN_BITS,
  localparam int SEL_BITS      = (KER_NUM > 1) ? $clog2(KER_NUM) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [DRAM_ADDR_BITS-1:0] cmd_dram_addr,
  input  logic [SEL_BITS-1:0]       cmd_ker_sel,
  input  logic [KER_ADDR_BITS-1:0]  cmd_ker_addr,
  input  logic [LEN_BITS-1:0]       cmd_words,
  output logic                      dram_rd_req,
  output logic [DRAM_ADDR_BITS-1:0] dram_rd_addr,
  output logic [LEN_BITS-1:0]       dram_rd_len,
  input  logic                      dram_rd_gnt,
  input  logic [DRAM_DATA_BITS-1:0] dram_rd_data,
  input  logic                      dram_rd_valid,
  output logic                      dram_rd_ready,
  output logic [KER_NUM-1:0]        ker_wr_en,
  output logic [KER_ADDR_BITS-1:0]  ker_wr_addr,
  output logic [KER_WIDTH-1:0]      ker_wr_data,
  output logic                      done,
  output logic                      err
`ifdef KER_LOADER_PERF_EN
  ,
  output logic [31:0]               perf_cycles
`endif
);

  localparam int R         = DRAM_DATA_BITS / KER_WIDTH;
  localparam int LANE_BITS = kl_lane_bits(R);

  ker_loader_state_e state, state_nxt;

  logic [DRAM_ADDR_BITS-1:0] dram_addr_q;
  logic [LEN_BITS-1:0]       beats_q;
  logic [LEN_BITS-1:0]       remain_q;
  logic [KER_ADDR_BITS-1:0]  wr_addr_q;
  logic [SEL_BITS-1:0]       sel_q;
  logic                      err_q;

  logic                      accept;
  logic                      beat_take;
  logic                      write_now;
  logic                      reject;
  logic [31:0]               end_row;
  logic [LEN_BITS:0]         words_round;
  logic [LEN_BITS-1:0]       beats_calc;
  logic [LANE_BITS:0]        lanes_left;
  logic [KER_NUM-1:0]        sel_onehot;

  // Command screening: the bank range is checked with wide arithmetic so it never wraps.
  assign end_row     = 32'(cmd_ker_addr) + 32'(cmd_words);
  assign reject      = (end_row > 32'(KER_HEIGHT)) || (32'(cmd_ker_sel) >= 32'(KER_NUM));
  assign words_round = {1'b0, cmd_words} + (LEN_BITS + 1)'(R - 1);
  assign beats_calc  = LEN_BITS'(words_round / (LEN_BITS + 1)'(R));
  assign sel_onehot  = KER_NUM'(1) << sel_q;

  // Next-state and handshake decode; every output defaults low except where a state drives it.
  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    dram_rd_req   = 1'b0;
    dram_rd_ready = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    accept        = 1'b0;
    beat_take     = 1'b0;
    write_now     = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_words == '0 || reject) begin
            state_nxt = ST_FIN;
          end else begin
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        dram_rd_req = 1'b1;
        if (dram_rd_gnt) begin
          state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        dram_rd_ready = 1'b1;
        if (dram_rd_valid) begin
          beat_take = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        write_now = 1'b1;
        // Last word of the command ends the transfer even mid-beat; the leftover lanes are dropped.
        if (remain_q == LEN_BITS'(1)) begin
          state_nxt = ST_FIN;
        end else if (lanes_left == (LANE_BITS + 1)'(1)) begin
          state_nxt = ST_RECV;
        end
      end
      ST_FIN: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register, latched command fields, write address/remaining counters and registered write enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dram_addr_q <= '0;
      beats_q     <= '0;
      remain_q    <= '0;
      wr_addr_q   <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
      ker_wr_en   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dram_addr_q <= cmd_dram_addr;
        beats_q     <= beats_calc;
        remain_q    <= cmd_words;
        wr_addr_q   <= cmd_ker_addr;
        sel_q       <= cmd_ker_sel;
        err_q       <= (cmd_words != '0) && reject;
      end
      if (write_now) begin
        wr_addr_q <= wr_addr_q + KER_ADDR_BITS'(1);
        remain_q  <= remain_q - LEN_BITS'(1);
      end
      ker_wr_en <= (state_nxt == ST_WRITE) ? sel_onehot : '0;
    end
  end

  assign dram_rd_addr = dram_addr_q;
  assign dram_rd_len  = beats_q;
  assign ker_wr_addr  = wr_addr_q;

  beat_splitter #(
    .LANES      (R),
    .LANE_WIDTH (KER_WIDTH),
    .LANE_BITS  (LANE_BITS)
  ) u_splitter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (beat_take),
    .shift      (write_now),
    .beat       (dram_rd_data),
    .lane       (ker_wr_data),
    .lanes_left (lanes_left)
  );

`ifdef KER_LOADER_PERF_EN
  logic [31:0] perf_run;

  // Running count starts at 1 on the accept cycle; the FIN cycle itself is included when latching.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_run    <= '0;
      perf_cycles <= '0;
    end else begin
      if (accept) begin
        perf_run <= 32'd1;
      end else if (state != ST_IDLE && perf_run != '1) begin
        perf_run <= perf_run + 32'd1;
      end
      if (state == ST_FIN) begin
        perf_cycles <= (perf_run == '1) ? '1 : perf_run + 32'd1;
      end
    end
  end
`endif

endmodule
